// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one burst-capable memory between an instruction port and a data port.
// One transaction at a time; reads end with a one-cycle drain that carries the last registered memory word.
module mem_arbiter #(
  parameter int ADDRESS_SIZE = 32,
  parameter int DATA_SIZE    = 32,
  parameter int ACCESS_SIZE  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  // instruction port
  input  logic                    i_req,
  input  logic                    i_wren,
  input  logic [ADDRESS_SIZE-1:0] i_addr,
  input  logic [ACCESS_SIZE-1:0]  i_acc_size,
  input  logic [DATA_SIZE-1:0]    i_wdata,
  output logic                    i_gnt,
  output logic [DATA_SIZE-1:0]    i_rdata,
  output logic                    i_rvalid,
  output logic                    i_done,
  // data port
  input  logic                    d_req,
  input  logic                    d_wren,
  input  logic [ADDRESS_SIZE-1:0] d_addr,
  input  logic [ACCESS_SIZE-1:0]  d_acc_size,
  input  logic [DATA_SIZE-1:0]    d_wdata,
  output logic                    d_gnt,
  output logic [DATA_SIZE-1:0]    d_rdata,
  output logic                    d_rvalid,
  output logic                    d_done,
  // memory side
  output logic [ADDRESS_SIZE-1:0] mem_addr,
  output logic [ACCESS_SIZE-1:0]  mem_acc_size,
  output logic                    mem_wren,
  output logic                    mem_en,
  output logic [DATA_SIZE-1:0]    mem_d_in,
  input  logic [DATA_SIZE-1:0]    mem_d_out
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BURST = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_next_state;
  logic [4:0]              r_beat;
  logic [4:0]              w_beats;
  logic                    w_last_beat;
  logic                    r_last_d;
  logic                    r_owner_d;
  logic                    r_wren;
  logic [ADDRESS_SIZE-1:0] r_addr;
  logic [ACCESS_SIZE-1:0]  r_size;
  logic                    w_grant;
  logic                    w_win_d;
  logic                    w_gnt;
  logic                    w_rvalid;
  logic                    w_done;
  logic [DATA_SIZE-1:0]    r_i_rdata;
  logic [DATA_SIZE-1:0]    r_d_rdata;

  // Burst length decoded from the latched size code, so mid-burst request changes cannot alter it.
  always_comb begin
    case (r_size[1:0])
      2'b00:   w_beats = 5'd1;
      2'b01:   w_beats = 5'd4;
      2'b10:   w_beats = 5'd8;
      default: w_beats = 5'd16;
    endcase
  end

  assign w_last_beat = (r_beat == (w_beats - 5'd1));

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no branch can leave a latch behind.
    w_next_state = r_state;
    w_grant      = 1'b0;
    w_win_d      = 1'b0;
    w_gnt        = 1'b0;
    w_rvalid     = 1'b0;
    w_done       = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (i_req || d_req) begin
          w_grant      = 1'b1;
          // On a tie the port that did not win last time goes first.
          w_win_d      = d_req && (!i_req || !r_last_d);
          w_next_state = S_BURST;
        end
      end
      S_BURST: begin
        w_gnt    = 1'b1;
        w_rvalid = !r_wren && (r_beat != 5'd0);
        if (w_last_beat) begin
          if (r_wren) begin
            w_done       = 1'b1;
            w_next_state = S_IDLE;
          end else begin
            w_next_state = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        w_rvalid     = 1'b1;
        w_done       = 1'b1;
        w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_beat    <= 5'd0;
      r_last_d  <= 1'b1;
      r_owner_d <= 1'b0;
      r_wren    <= 1'b0;
      r_addr    <= '0;
      r_size    <= '0;
    end else begin
      if (w_grant) begin
        r_owner_d <= w_win_d;
        r_last_d  <= w_win_d;
        r_wren    <= w_win_d ? d_wren     : i_wren;
        r_addr    <= w_win_d ? d_addr     : i_addr;
        r_size    <= w_win_d ? d_acc_size : i_acc_size;
      end
      if ((r_state == S_BURST) && !w_last_beat) begin
        r_beat <= r_beat + 5'd1;
      end else begin
        r_beat <= 5'd0;
      end
    end
  end

  // Read data passes straight through while valid and is held afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_i_rdata <= '0;
      r_d_rdata <= '0;
    end else begin
      if (i_rvalid) r_i_rdata <= mem_d_out;
      if (d_rvalid) r_d_rdata <= mem_d_out;
    end
  end

  assign i_gnt    = w_gnt    && !r_owner_d;
  assign d_gnt    = w_gnt    &&  r_owner_d;
  assign i_rvalid = w_rvalid && !r_owner_d;
  assign d_rvalid = w_rvalid &&  r_owner_d;
  assign i_done   = w_done   && !r_owner_d;
  assign d_done   = w_done   &&  r_owner_d;
  assign i_rdata  = i_rvalid ? mem_d_out : r_i_rdata;
  assign d_rdata  = d_rvalid ? mem_d_out : r_d_rdata;

  assign mem_addr     = r_addr;
  assign mem_acc_size = r_size;
  assign mem_wren     = r_wren && (r_state == S_BURST);
  assign mem_en       = (r_state == S_BURST) && (r_beat == 5'd0);
  assign mem_d_in     = r_owner_d ? d_wdata : i_wdata;

endmodule
